// File: rtl/keccak_round_sequencer.sv
// keccak_round_sequencer
// Iterative Keccak-f[1600] job driver around a one-round permutation stage.
module keccak_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 24
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1599:0] in_state,
   input  logic          abort,
   output logic          busy,
   output logic [1599:0] perm_in,
   output logic [6:0]    perm_rc,
   input  logic [1599:0] perm_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1599:0] out_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS - 1);

   logic [1:0]    fsm_q, fsm_d;
   logic [4:0]    round_q, round_d;
   logic [1599:0] state_q, state_d;
   logic [6:0]    rc;
   logic          in_idle, in_run, in_done;
   logic          load;

   assign in_idle = (fsm_q == S_IDLE);
   assign in_run  = (fsm_q == S_RUN);
   assign in_done = (fsm_q == S_DONE);

   // A new job can enter from IDLE, or from DONE in the same cycle the
   // result leaves, which removes the bubble between back-to-back jobs.
   assign in_ready = reset_n & ~abort & (in_idle | (in_done & out_ready));
   assign load     = in_valid & in_ready;

   assign busy      = in_run;
   assign out_valid = in_done;
   assign perm_in   = state_q;
   assign out_state = state_q;
   assign perm_rc   = in_run ? rc : 7'd0;

   // Compressed round-constant ROM; bits map to lane(0,0) {63,31,15,7,3,1,0}
   always_comb begin
      rc = 7'd0;
      case (round_q)
         5'd0:    rc = 7'h01;
         5'd1:    rc = 7'h1A;
         5'd2:    rc = 7'h5E;
         5'd3:    rc = 7'h70;
         5'd4:    rc = 7'h1F;
         5'd5:    rc = 7'h21;
         5'd6:    rc = 7'h79;
         5'd7:    rc = 7'h55;
         5'd8:    rc = 7'h0E;
         5'd9:    rc = 7'h0C;
         5'd10:   rc = 7'h35;
         5'd11:   rc = 7'h26;
         5'd12:   rc = 7'h3F;
         5'd13:   rc = 7'h4F;
         5'd14:   rc = 7'h5D;
         5'd15:   rc = 7'h53;
         5'd16:   rc = 7'h52;
         5'd17:   rc = 7'h48;
         5'd18:   rc = 7'h16;
         5'd19:   rc = 7'h66;
         5'd20:   rc = 7'h79;
         5'd21:   rc = 7'h58;
         5'd22:   rc = 7'h21;
         5'd23:   rc = 7'h74;
         default: rc = 7'd0;
      endcase
   end

   // Next state: abort beats everything, then job load, then round stepping
   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      if (abort) begin
         fsm_d   = S_IDLE;
         round_d = 5'd0;
      end else if (load) begin
         fsm_d   = S_RUN;
         round_d = 5'd0;
         state_d = in_state;
      end else begin
         case (fsm_q)
            S_RUN: begin
               state_d = perm_out;
               if (round_q == LAST_RND) begin
                  fsm_d   = S_DONE;
                  round_d = 5'd0;
               end else begin
                  round_d = round_q + 5'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  fsm_d = S_IDLE;
               end
            end
            S_IDLE: begin
               fsm_d = S_IDLE;
            end
            default: begin
               fsm_d   = S_IDLE;
               round_d = 5'd0;
            end
         endcase
      end
   end

   // State, round counter and FSM registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= S_IDLE;
         round_q <= 5'd0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
      end
   end

endmodule
